// File: rtl/load_store_unit.sv
// RV32I load/store unit: takes the effective address from execute, runs one
// data-memory transaction at a time, and reports completion with error flags.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_err,
   output logic        illegal,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   // state | meaning
   // IDLE  | ready for a request; error flags cleared
   // REQ   | mem_req held until mem_gnt or timeout
   // RESP  | load granted, waiting for mem_rvalid or timeout
   // FIN   | one-cycle done pulse with error flags
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FIN} state_e;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          is_store_q;
   logic [2:0]    funct3_q;
   logic [31:0]   addr_q, sd_q;
   logic [31:0]   load_data_q;
   logic          mis_q, mis_d, ill_q, ill_d, berr_q, berr_d;
   logic          latch_en, ld_en;
   logic          req_mis, req_ill;
   logic [31:0]   byte_sh, half_sh, ld_ext;

   assign req_ill = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
   assign req_mis = (((funct3 == 3'b001) || (funct3 == 3'b101)) && addr[0]) ||
                    ((funct3 == 3'b010) && (addr[1:0] != 2'b00));

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mis_d    = mis_q;
      ill_d    = ill_q;
      berr_d   = berr_q;
      latch_en = 1'b0;
      ld_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            mis_d  = 1'b0;
            ill_d  = 1'b0;
            berr_d = 1'b0;
            cnt_d  = '0;
            if (req_valid) begin
               latch_en = 1'b1;
               mis_d    = req_mis;
               ill_d    = req_ill;
               state_d  = (req_mis || req_ill) ? S_FIN : S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               cnt_d   = '0;
               state_d = is_store_q ? S_FIN : S_RESP;
            end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
               cnt_d   = '0;
               berr_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_RESP: begin
            if (mem_rvalid) begin
               cnt_d   = '0;
               ld_en   = 1'b1;
               state_d = S_FIN;
            end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
               cnt_d   = '0;
               berr_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byte_sh = mem_rdata >> {addr_q[1:0], 3'b000};
      half_sh = mem_rdata >> {addr_q[1], 4'b0000};
      case (funct3_q)
         3'b000:  ld_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
         3'b001:  ld_ext = {{16{half_sh[15]}}, half_sh[15:0]};
         3'b100:  ld_ext = {24'h0, byte_sh[7:0]};
         3'b101:  ld_ext = {16'h0, half_sh[15:0]};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         is_store_q  <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= '0;
         sd_q        <= '0;
         load_data_q <= '0;
         mis_q       <= 1'b0;
         ill_q       <= 1'b0;
         berr_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mis_q   <= mis_d;
         ill_q   <= ill_d;
         berr_q  <= berr_d;
         if (latch_en) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            addr_q     <= addr;
            sd_q       <= store_data;
         end
         if (ld_en) begin
            load_data_q <= ld_ext;
         end
      end
   end

   // Lane signals derive from the latched request so they stay stable through REQ.
   always_comb begin
      mem_wstrb = 4'b0000;
      mem_wdata = '0;
      if (is_store_q) begin
         case (funct3_q)
            3'b000: begin
               mem_wstrb = 4'b0001 << addr_q[1:0];
               mem_wdata = {4{sd_q[7:0]}};
            end
            3'b001: begin
               mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
               mem_wdata = {2{sd_q[15:0]}};
            end
            3'b010: begin
               mem_wstrb = 4'b1111;
               mem_wdata = sd_q;
            end
            default: begin
               mem_wstrb = 4'b0000;
               mem_wdata = '0;
            end
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_FIN);
   assign mem_req    = (state_q == S_REQ);
   assign mem_we     = (state_q == S_REQ) && is_store_q;
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign load_data  = load_data_q;
   assign misaligned = mis_q;
   assign illegal    = ill_q;
   assign bus_err    = berr_q;

endmodule
